// File: rtl/coord_sweep_gen_if.sv
// rtl/coord_sweep_gen_if.sv - pixel/coordinate issue bus from the sweep generator to the solver channels
interface coord_sweep_gen_if #(
  parameter int COORD_W = 36,
  parameter int XPIX    = 640,
  parameter int YPIX    = 480,
  parameter int NUM_CH  = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int X_W  = (XPIX > 1) ? $clog2(XPIX) : 1;
  localparam int Y_W  = (YPIX > 1) ? $clog2(YPIX) : 1;

  logic [NUM_CH-1:0]  i_rdy;
  logic               o_val;
  logic [CH_W-1:0]    o_ch;
  logic [X_W-1:0]     o_vga_x;
  logic [Y_W-1:0]     o_vga_y;
  logic [COORD_W-1:0] o_coord_x;
  logic [COORD_W-1:0] o_coord_y;

  modport master (
    input  i_rdy,
    output o_val, o_ch, o_vga_x, o_vga_y, o_coord_x, o_coord_y
  );

  modport slave (
    output i_rdy,
    input  o_val, o_ch, o_vga_x, o_vga_y, o_coord_x, o_coord_y
  );
endinterface

// File: rtl/coord_sweep_gen.sv
// rtl/coord_sweep_gen.sv - raster sweep generator issuing per-pixel complex coordinates to solver channels
// Optional feature: COORD_SWEEP_SERPENTINE_EN (odd rows scan right-to-left).
module coord_sweep_gen #(
  parameter int COORD_W = 36,
  parameter int XPIX    = 640,
  parameter int YPIX    = 480,
  parameter int NUM_CH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw,
  input  logic [4:0]         zoom,
  input  logic [COORD_W-1:0] upper_left_x,
  input  logic [COORD_W-1:0] upper_left_y,
  input  logic [COORD_W-1:0] step_x,
  input  logic [COORD_W-1:0] step_y,
  coord_sweep_gen_if.master  bus,
  output logic               o_busy,
  output logic               o_done
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int X_W  = (XPIX > 1) ? $clog2(XPIX) : 1;
  localparam int Y_W  = (YPIX > 1) ? $clog2(YPIX) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(XPIX - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(YPIX - 1);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [X_W-1:0]     col_q, col_d;
  logic [Y_W-1:0]     row_q, row_d;
  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;
  logic [COORD_W-1:0] ox_q, ox_d;
  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;

  logic               any_rdy;
  logic [CH_W-1:0]    pick;
  logic               sel_rdy;
  logic               xfer;
  logic               rev;
  logic               row_end;

  // Lowest-index ready channel wins arbitration
  always_comb begin
    pick    = '0;
    any_rdy = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.i_rdy[i]) begin
        pick    = CH_W'(i);
        any_rdy = 1'b1;
      end
    end
  end

  // Only the readiness of the channel currently being offered matters
  always_comb begin
    sel_rdy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) sel_rdy = bus.i_rdy[i];
    end
  end

  assign xfer = (state_q == ISSUE) && sel_rdy;

`ifdef COORD_SWEEP_SERPENTINE_EN
  assign rev = row_q[0];
`else
  assign rev = 1'b0;
`endif

  // A reversed row ends at column 0, a forward row at the last column
  assign row_end = rev ? (col_q == '0) : (col_q == X_LAST);

  // Next-state and datapath update; draw overrides everything except reset
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    col_d   = col_q;
    row_d   = row_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ox_d    = ox_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      IDLE: state_d = IDLE;
      ARB: begin
        if (any_rdy) begin
          ch_d    = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (!row_end) begin
            state_d = ARB;
            if (rev) begin
              col_d = col_q - X_W'(1);
              cx_d  = cx_q - sx_q;
            end else begin
              col_d = col_q + X_W'(1);
              cx_d  = cx_q + sx_q;
            end
          end else if (row_q != Y_LAST) begin
            state_d = ARB;
            row_d   = row_q + Y_W'(1);
            cy_d    = cy_q + sy_q;
`ifndef COORD_SWEEP_SERPENTINE_EN
            col_d   = '0;
            cx_d    = ox_q;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (draw) begin
      ox_d    = upper_left_x;
      sx_d    = step_x >> zoom;
      sy_d    = step_y >> zoom;
      col_d   = '0;
      row_d   = '0;
      cx_d    = upper_left_x;
      cy_d    = upper_left_y;
      state_d = ARB;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ox_q    <= ox_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign bus.o_val     = (state_q == ISSUE);
  assign bus.o_ch      = ch_q;
  assign bus.o_vga_x   = col_q;
  assign bus.o_vga_y   = row_q;
  assign bus.o_coord_x = cx_q;
  assign bus.o_coord_y = cy_q;
  assign o_busy        = (state_q == ARB) || (state_q == ISSUE);
  assign o_done        = (state_q == DONE);
endmodule

// File: doc/coord_sweep_gen.md
COORD_SWEEP_GEN -- requirements
Module: coord_sweep_gen

Interface
REQ-001 SHALL provide parameter COORD_W, default 36, fixed-point coordinate width (4.32 two's complement at default).
REQ-002 SHALL provide parameter XPIX, default 640, pixels per row.
REQ-003 SHALL provide parameter YPIX, default 480, rows per frame.
REQ-004 SHALL provide parameter NUM_CH, default 4, number of downstream solver channels; CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have: draw  in  1  start/restart frame pulse; zoom  in  5  step right-shift amount.
REQ-007 SHALL have: upper_left_x, upper_left_y  in  COORD_W  frame origin; step_x, step_y  in  COORD_W  unzoomed per-pixel increments.
REQ-008 SHALL have: i_rdy  in  NUM_CH  per-channel ready; o_val  out  1  pixel valid; o_ch  out  CH_W  target channel.
REQ-009 SHALL have: o_vga_x  out  clog2(XPIX)  column; o_vga_y  out  clog2(YPIX)  row; o_coord_x, o_coord_y  out  COORD_W  complex-plane coordinate.
REQ-010 SHALL have: o_busy  out  1  frame in progress; o_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-011 SHALL implement states IDLE, ARB, ISSUE, DONE.
REQ-012 On draw=1 in any state: latch origin, sx = step_x >> zoom, sy = step_y >> zoom (logical shift); clear pixel counters; load coords with origin; next state ARB; o_val=0 next cycle.
REQ-013 Inputs other than draw and i_rdy SHALL be ignored outside the draw cycle; changes mid-frame have no effect.
REQ-014 ARB: if i_rdy != 0, register lowest-index set bit into o_ch and go ISSUE; else remain in ARB.
REQ-015 ISSUE: o_val=1; o_ch, o_vga_x/y, o_coord_x/y SHALL remain stable until transfer.
REQ-016 Transfer occurs on a cycle with o_val=1 and i_rdy[o_ch]=1; readiness of other channels SHALL be ignored.
REQ-017 On transfer with column < XPIX-1: column+1, coord_x += sx, go ARB.
REQ-018 On transfer at column XPIX-1, row < YPIX-1: column 0, coord_x = latched origin x, row+1, coord_y += sy, go ARB.
REQ-019 On transfer at last pixel: go DONE; o_done=1 for exactly one cycle; then IDLE.
REQ-020 Coordinate additions SHALL be modulo 2^COORD_W (silent wrap, no saturation).
REQ-021 Minimum issue rate: one pixel per 2 cycles; exactly XPIX*YPIX transfers per uninterrupted frame.
REQ-022 draw coincident with a transfer: transfer counts downstream, but draw wins; frame restarts, no advance.
REQ-023 o_busy=1 in ARB and ISSUE, else 0.
REQ-024 draw in IDLE or DONE SHALL start a new frame; no draw leaves the block in IDLE with o_val=0.

Reset
REQ-025 reset=0 sampled at a clk edge SHALL force IDLE, o_val=0, o_ch=0, o_vga_x=0, o_vga_y=0, o_coord_x=0, o_coord_y=0, o_busy=0, o_done=0, latched steps/origin=0.
REQ-026 Reset SHALL take priority over draw; reset mid-frame aborts without o_done.

Configuration
REQ-027 Macro COORD_SWEEP_SERPENTINE_EN defined: odd rows SHALL scan right-to-left (column XPIX-1 down to 0, coord_x -= sx); row change keeps column and coord_x, only row/coord_y advance.
REQ-028 Macro undefined: every row scans left-to-right per REQ-017/018.

Verification
REQ-029 XPIX=4, YPIX=3, NUM_CH=2, i_rdy=2'b11, draw with origin 0, step_x=0x100, zoom=0 -> 12 transfers, all o_ch=0, last coord_x=0x300, o_done pulse once.
REQ-030 i_rdy=2'b10 held -> every transfer on o_ch=1; i_rdy=0 for 10 cycles -> o_val=0, block in ARB, counters frozen.
REQ-031 step_x=0x800, zoom=3 -> sx=0x100; mid-frame change of zoom -> increments unchanged.
REQ-032 origin x=0xF_FFFFFF00, sx=0x100 -> second pixel coord_x=0 (wrap).
REQ-033 reset=0 during row 1 -> all outputs zero next cycle, no o_done; draw mid-frame -> restart at (0,0) with origin.
REQ-034 SERPENTINE_EN, XPIX=4 -> row 1 o_vga_x sequence 3,2,1,0 with coord_x decreasing by sx.
